instr_sequencer: RTL and testbench

- Multi-cycle control FSM for the tiny CPU core.
- Fetches each instruction, classifies it by opcode, and sequences the ALU/register-file write, data-memory access, branch redirect and HALT.
- Drives the program counter through one-cycle increment/load strobes; the PC register itself lives in a separate block and advances by 4 per pc_inc.
- Keeps a retired-instruction counter for bring-up and debug.

---
 rtl/instr_sequencer.sv | 172 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle control FSM for the tiny CPU core. Fetches an instruction,
//   classifies it by opcode and sequences the ALU write-back, data-memory
//   access, branch redirect or HALT. The PC register lives elsewhere; this
//   block only issues one-cycle pc_inc / pc_load strobes. A retired-instruction
//   counter is kept for bring-up and debug.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   instr_valid   instruction memory returns a valid word this cycle
//   instr         fetched instruction word
//   mem_ready     data memory completes the current access this cycle
//   branch_taken  ALU compare result for the instruction held in ir
//   instr_req     fetch request (FETCH state)
//   ir            latched instruction register
//   pc_inc        one-cycle strobe: PC += 4
//   pc_load       one-cycle strobe: PC <= pc_target
//   pc_target     branch target {ir[31 -: PC_WIDTH-2], 2'b00}
//   reg_we        register-file write enable
//   mem_req       data-memory request, mem_we qualifies it as a store
//   halted        core is halted (registered)
//   illegal       one-cycle pulse on an unrecognised opcode
//   state         current FSM state encoding
//   retired_cnt   retired-instruction count, wraps
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int PC_WIDTH  = 7,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 instr_req,
  output logic [31:0]          ir,
  output logic                 pc_inc,
  output logic                 pc_load,
  output logic [PC_WIDTH-1:0]  pc_target,
  output logic                 reg_we,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 halted,
  output logic                 illegal,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_HALT,
    C_ILLEGAL
  } iclass_e;

  state_e                 state_q, state_d;
  logic [31:0]            ir_q;
  logic [CNT_WIDTH-1:0]   retired_cnt_q;
  logic                   halted_q;
  iclass_e                iclass;

  // Opcode classification of the instruction currently held in ir.
  always_comb begin
    unique case (ir_q[6:0])
      7'b0110011, 7'b0010011: iclass = C_ALU;
      7'b0000011:             iclass = C_LOAD;
      7'b0100011:             iclass = C_STORE;
      7'b1100011:             iclass = C_BRANCH;
      7'b0000001:             iclass = C_HALT;
      default:                iclass = C_ILLEGAL;
    endcase
  end

  // Next state and combinational strobes.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    instr_req = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    reg_we    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          C_ALU, C_BRANCH: state_d = S_EXEC;
          C_LOAD, C_STORE: state_d = S_MEM;
          C_HALT:          state_d = S_HALT;
          default: begin
            // Unknown opcode retires as a NOP straight out of DECODE.
            illegal = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        if (iclass == C_BRANCH) begin
          pc_load = branch_taken;
          pc_inc  = ~branch_taken;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (iclass == C_STORE);
        if (mem_ready) begin
          if (iclass == C_STORE) begin
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;  // unused code 7 recovers
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous to match the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ir_q          <= '0;
      retired_cnt_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALT);
      if (state_q == S_FETCH && instr_valid) ir_q <= instr;
      if (pc_inc | pc_load) retired_cnt_q <= retired_cnt_q + 1'b1;
    end
  end

  assign ir          = ir_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign retired_cnt = retired_cnt_q;
  assign pc_target   = {ir_q[31 -: PC_WIDTH-2], 2'b00};

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//   Builds, per instruction, the expected cycle-by-cycle trace (state, strobes,
//   ir, retire count) from the instruction class and the chosen wait times,
//   drives the DUT from that trace and compares every cycle.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int PW = 7;
  localparam int CW = 10;  // narrow counter so the wrap is reachable quickly

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5,
                         ST_HALT = 3'd6;

  // Strobe vector order: {instr_req,pc_inc,pc_load,reg_we,mem_req,mem_we,illegal,halted}
  localparam logic [7:0] B_REQ = 8'h80, B_INC = 8'h40, B_LD = 8'h20, B_WE = 8'h10,
                         B_MREQ = 8'h08, B_MWE = 8'h04, B_ILL = 8'h02, B_HLT = 8'h01;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_HLT = 7'b0000001;

  logic          clk = 1'b0, rst = 1'b0;
  logic          instr_valid = 1'b0, mem_ready = 1'b0, branch_taken = 1'b0;
  logic [31:0]   instr = '0;
  logic          instr_req, pc_inc, pc_load, reg_we, mem_req, mem_we, halted, illegal;
  logic [31:0]   ir;
  logic [PW-1:0] pc_target;
  logic [2:0]    state;
  logic [CW-1:0] retired_cnt;

  instr_sequencer #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .instr_req(instr_req),
    .ir(ir), .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
    .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .halted(halted),
    .illegal(illegal), .state(state), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  strb;
    logic        iv, mr, bt;
    logic [31:0] instr;
    logic [31:0] ir;
  } cyc_t;

  cyc_t        trace[$];
  int          errors = 0;
  int          checks = 0;
  int          model_cnt = 0;
  logic [31:0] model_ir = '0;
  bit          stray = 1'b0;
  int          cyc_no = 0;

  // Don't-care input value: random noise when stray stimulus is enabled.
  function automatic logic rnd();
    return stray ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_HLT};
  endfunction

  task automatic push(input logic [2:0] st, input logic [7:0] strb,
                      input logic iv, input logic mr, input logic bt,
                      input logic [31:0] w);
    cyc_t c;
    c.st = st; c.strb = strb; c.iv = iv; c.mr = mr; c.bt = bt;
    c.instr = w; c.ir = model_ir;
    trace.push_back(c);
  endtask

  // Expected trace of one instruction starting from FETCH entry.
  task automatic add_instr(input logic [31:0] w, input int fwait, input int mwait,
                           input bit taken, input int hcycles);
    logic [6:0] op = w[6:0];
    logic [7:0] we;
    for (int i = 0; i < fwait; i++) push(ST_FETCH, B_REQ, 1'b0, rnd(), rnd(), $urandom);
    push(ST_FETCH, B_REQ, 1'b1, rnd(), rnd(), w);
    model_ir = w;
    push(ST_DECODE, is_legal(op) ? 8'h00 : (B_INC | B_ILL), rnd(), rnd(), rnd(), $urandom);
    if (op == OP_R || op == OP_I) begin
      push(ST_EXEC, 8'h00, rnd(), rnd(), rnd(), $urandom);
      push(ST_WB, B_WE | B_INC, rnd(), rnd(), rnd(), $urandom);
    end else if (op == OP_BR) begin
      push(ST_EXEC, taken ? B_LD : B_INC, rnd(), rnd(), taken, $urandom);
    end else if (op == OP_LD || op == OP_ST) begin
      we = (op == OP_ST) ? B_MWE : 8'h00;
      for (int i = 0; i < mwait; i++) push(ST_MEM, B_MREQ | we, rnd(), 1'b0, rnd(), $urandom);
      push(ST_MEM, B_MREQ | we | ((op == OP_ST) ? B_INC : 8'h00), rnd(), 1'b1, rnd(), $urandom);
      if (op == OP_LD) push(ST_WB, B_WE | B_INC, rnd(), rnd(), rnd(), $urandom);
    end else if (op == OP_HLT) begin
      for (int i = 0; i < hcycles; i++) push(ST_HALT, B_HLT, rnd(), rnd(), rnd(), $urandom);
    end
  endtask

  // Drive the first n trace entries, compare every cycle, then drop the trace.
  task automatic run_trace(input int n);
    cyc_t          c;
    logic [7:0]    got;
    logic [PW-1:0] tgt;
    logic [CW-1:0] ecnt;
    for (int i = 0; i < n && i < trace.size(); i++) begin
      c = trace[i];
      @(negedge clk);
      instr_valid = c.iv; mem_ready = c.mr; branch_taken = c.bt; instr = c.instr;
      #1;
      cyc_no++;
      got  = {instr_req, pc_inc, pc_load, reg_we, mem_req, mem_we, illegal, halted};
      tgt  = {c.ir[31 -: PW-2], 2'b00};
      ecnt = CW'(model_cnt);
      checks += 5;
      if (state !== c.st) begin
        errors++; $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc_no, state, c.st);
      end
      if (got !== c.strb) begin
        errors++; $display("FAIL strobes cyc=%0d st=%0d got=%b exp=%b", cyc_no, c.st, got, c.strb);
      end
      if (ir !== c.ir) begin
        errors++; $display("FAIL ir cyc=%0d got=%h exp=%h", cyc_no, ir, c.ir);
      end
      if (pc_target !== tgt) begin
        errors++; $display("FAIL pc_target cyc=%0d got=%h exp=%h", cyc_no, pc_target, tgt);
      end
      if (retired_cnt !== ecnt) begin
        errors++; $display("FAIL retired_cnt cyc=%0d got=%0d exp=%0d", cyc_no, retired_cnt, ecnt);
      end
      if (c.strb & (B_INC | B_LD)) model_cnt++;
    end
    trace.delete();
  endtask

  task automatic exec(input logic [31:0] w, input int fwait, input int mwait,
                      input bit taken, input int hcycles);
    add_instr(w, fwait, mwait, taken, hcycles);
    run_trace(1000);
  endtask

  // Reset with noisy inputs; the first sampled cycle must be the clean IDLE state.
  task automatic do_reset();
    logic [7:0] got;
    @(negedge clk);
    rst = 1'b1;
    instr_valid = 1'($urandom); mem_ready = 1'($urandom);
    branch_taken = 1'($urandom); instr = $urandom;
    @(negedge clk);
    rst = 1'b0;
    #1;
    got = {instr_req, pc_inc, pc_load, reg_we, mem_req, mem_we, illegal, halted};
    checks += 4;
    if (state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got=%0d exp=0", state);
    end
    if (got !== 8'h00) begin
      errors++; $display("FAIL reset_strobes got=%b exp=00000000", got);
    end
    if (ir !== 32'h0) begin
      errors++; $display("FAIL reset_ir got=%h exp=0", ir);
    end
    if (retired_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt got=%0d exp=0", retired_cnt);
    end
    model_ir  = '0;
    model_cnt = 0;
  endtask

  // A few FETCH cycles with no valid instruction: state and count hold.
  task automatic fetch_idle(input int n);
    for (int i = 0; i < n; i++) push(ST_FETCH, B_REQ, 1'b0, rnd(), rnd(), $urandom);
    run_trace(n);
  endtask

  task automatic test_reset();
    stray = 1'b0;
    do_reset();
  endtask

  task automatic test_alu();
    exec(32'h002081B3, 0, 0, 1'b0, 0);
    fetch_idle(2);
    exec({25'h1234567, OP_I}, 2, 0, 1'b0, 0);
  endtask

  task automatic test_load_wait();
    exec(32'h00012083, 0, 3, 1'b0, 0);
  endtask

  task automatic test_store();
    exec(32'h00112023, 0, 0, 1'b0, 0);
    exec(32'h00112023, 1, 2, 1'b0, 0);
  endtask

  task automatic test_branch();
    exec(32'hFE000063, 0, 0, 1'b1, 0);
    exec(32'hFE000063, 0, 0, 1'b0, 0);
    exec(32'h50000063, 0, 0, 1'b1, 0);
  endtask

  task automatic test_illegal();
    exec(32'h0000007F, 0, 0, 1'b0, 0);
    exec(32'hABCDE000, 2, 0, 1'b0, 0);
  endtask

  task automatic test_halt();
    exec(32'h00000001, 0, 0, 1'b0, 20);
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    // FETCH, DECODE, then two MEM wait cycles before reset hits.
    add_instr(32'h00012083, 0, 6, 1'b0, 0);
    run_trace(4);
    do_reset();
    fetch_idle(1);
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [6:0]  op;
    stray = 1'b1;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      w = $urandom;
      case ($urandom_range(0, 5))
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LD;
        3: op = OP_ST;
        4: op = OP_BR;
        default: begin
          op = 7'($urandom);
          while (is_legal(op)) op = 7'($urandom);
        end
      endcase
      w[6:0] = op;
      exec(w, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), 0);
    end
    exec(32'h00000001, 1, 0, 1'b0, 5);
    stray = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < (1 << CW) + 3; n++) exec(32'h0000007F, 0, 0, 1'b0, 0);
    fetch_idle(1);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_branch();
    test_illegal();
    test_halt();
    test_reset_mid_mem();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
